// File: rtl/core_writeback_arbiter.sv
// core_writeback_arbiter
//   Collects results from the execution units (alu_a, alu_b, mul, ldst) into
//   one-entry holding slots. A round-robin arbiter drains up to two slots per
//   cycle onto register-file write ports A and B.
//
//   Optional build macro WB_CONFLICT_CNT_EN adds conflict_cnt. This 16-bit
//   saturating counter counts cycles in which a full slot was left ungranted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of all held results
//   req_valid[i]      result valid from requester i
//   req_ready[i]      slot i free (registered, = !full)
//   req_rd/req_value  packed per-requester destination register / result
//   wr_en_a/b         write port enables (registered)
//   wr_r_a/b          write port register numbers (registered)
//   wr_value_a/b      write port data (registered)
//   busy              any slot full
//   conflict_cnt      (WB_CONFLICT_CNT_EN only) stalled-slot cycle counter
module core_writeback_arbiter #(
  parameter int N_REQ = 4,
  parameter int RW    = 4,
  parameter int W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*RW-1:0]  req_rd,
  input  logic [N_REQ*W-1:0]   req_value,
  output logic                 wr_en_a,
  output logic [RW-1:0]        wr_r_a,
  output logic [W-1:0]         wr_value_a,
  output logic                 wr_en_b,
  output logic [RW-1:0]        wr_r_b,
  output logic [W-1:0]         wr_value_b,
  output logic                 busy
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]          conflict_cnt
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] slot_vld_p0;
  logic [RW-1:0]    slot_rd_p0    [N_REQ];
  logic [W-1:0]     slot_value_p0 [N_REQ];
  logic [IW-1:0]    rr_ptr;

  logic             a_vld, b_vld;
  logic [IW-1:0]    a_idx, b_idx, idx, last_idx, rr_next;
  logic [N_REQ-1:0] grant_mask;
  logic [N_REQ-1:0] cap;

  assign req_ready = ~slot_vld_p0;
  assign busy      = |slot_vld_p0;
  assign cap       = req_valid & ~slot_vld_p0;

  // Arbitration over the registered full flags. A slot whose rd matches
  // port A's rd is skipped, so both ports never write the same register.
  always_comb begin
    a_vld      = 1'b0;
    b_vld      = 1'b0;
    a_idx      = '0;
    b_idx      = '0;
    idx        = '0;
    grant_mask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N_REQ);
      if (slot_vld_p0[idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx;
        end else if (!b_vld && (slot_rd_p0[idx] != slot_rd_p0[a_idx])) begin
          b_vld = 1'b1;
          b_idx = idx;
        end
      end
    end
    if (a_vld) grant_mask[a_idx] = 1'b1;
    if (b_vld) grant_mask[b_idx] = 1'b1;
    last_idx = b_vld ? b_idx : a_idx;
    rr_next  = a_vld ? IW'((int'(last_idx) + 1) % N_REQ) : rr_ptr;
  end

  // Stage p0: holding slots (control flags, round-robin pointer)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_p0 <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      slot_vld_p0 <= '0;
    end else begin
      slot_vld_p0 <= (slot_vld_p0 & ~grant_mask) | cap;
      rr_ptr      <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (cap[i] && !flush) begin
        slot_rd_p0[i]    <= req_rd[i*RW +: RW];
        slot_value_p0[i] <= req_value[i*W +: W];
      end
    end
  end

  // Stage p1: registered write ports; data holds when a port is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_a    <= 1'b0;
      wr_en_b    <= 1'b0;
      wr_r_a     <= '0;
      wr_r_b     <= '0;
      wr_value_a <= '0;
      wr_value_b <= '0;
    end else if (flush) begin
      wr_en_a <= 1'b0;
      wr_en_b <= 1'b0;
    end else begin
      wr_en_a <= a_vld;
      wr_en_b <= b_vld;
      if (a_vld) begin
        wr_r_a     <= slot_rd_p0[a_idx];
        wr_value_a <= slot_value_p0[a_idx];
      end
      if (b_vld) begin
        wr_r_b     <= slot_rd_p0[b_idx];
        wr_value_b <= slot_value_p0[b_idx];
      end
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [N_REQ-1:0] left_mask;
  assign left_mask = slot_vld_p0 & ~grant_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (flush) begin
      conflict_cnt <= '0;
    end else if (|left_mask) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule
